// File: rtl/softmax_data_server.sv
// Responder end of the STAR input fetch interface: buffers one softmax vector from a host load
// port and serves one-cycle-latency reads. Define SOFTMAX_SRV_MAX_EN to add the running max xmax.
module softmax_data_server #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic          data_req,
  input  logic [AW-1:0] data_addr,
  output logic [DW-1:0] data,
  output logic          data_valid,
  input  logic          finish,
  output logic          buf_full,
  output logic [AW-1:0] vec_len,
  output logic          addr_err
`ifdef SOFTMAX_SRV_MAX_EN
  ,
  output logic signed [DW-1:0] xmax
`endif
);

  localparam int unsigned   IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StEmpty, StLoad, StServe} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] vec_len_q, vec_len_d;
  logic          ld_ready_q, ld_ready_d;
  logic [DW-1:0] data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic          addr_err_q, addr_err_d;
  logic [DW-1:0] mem [DEPTH];
  logic          ld_acc, rd_en, rd_in_range;

  assign ld_acc      = ld_valid & ld_ready_q;
  assign rd_en       = data_req & (state_q == StServe);
  assign rd_in_range = data_addr < vec_len_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    vec_len_d    = vec_len_q;
    addr_err_d   = addr_err_q;
    data_valid_d = rd_en;
    data_d       = '0;
    if (rd_en && rd_in_range) data_d = mem[data_addr[IW-1:0]];
    case (state_q)
      StEmpty, StLoad: begin
        // wr_ptr is 0 in StEmpty, so both load states share the write path
        if (ld_acc) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (ld_last || wr_ptr_q == LastIdx) begin
            state_d   = StServe;
            vec_len_d = wr_ptr_q + 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StServe: begin
        if (rd_en && !rd_in_range) addr_err_d = 1'b1;
        if (finish) begin
          state_d    = StEmpty;
          wr_ptr_d   = '0;
          vec_len_d  = '0;
          addr_err_d = 1'b0;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Registered so ld_ready falls the cycle after the final beat is accepted
    ld_ready_d = (state_d != StServe);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StEmpty;
      wr_ptr_q     <= '0;
      vec_len_q    <= '0;
      ld_ready_q   <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      vec_len_q    <= vec_len_d;
      ld_ready_q   <= ld_ready_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_acc) mem[wr_ptr_q[IW-1:0]] <= ld_data;
  end

  assign ld_ready   = ld_ready_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign buf_full   = (state_q == StServe);
  assign vec_len    = vec_len_q;
  assign addr_err   = addr_err_q;

`ifdef SOFTMAX_SRV_MAX_EN
  localparam logic signed [DW-1:0] XMin = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW-1:0] xmax_q, xmax_d, xbase;

  always_comb begin
    xbase  = (state_q == StEmpty) ? XMin : xmax_q;
    xmax_d = xmax_q;
    if (state_q == StEmpty) xmax_d = XMin;
    if (ld_acc) xmax_d = ($signed(ld_data) > xbase) ? $signed(ld_data) : xbase;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) xmax_q <= XMin;
    else        xmax_q <= xmax_d;
  end

  assign xmax = xmax_q;
`endif

endmodule
